// File: rtl/pll_cen_gen.sv
// Phase-aligned multi-channel clock-enable generator on refclk: runtime divide/high/phase per channel.
// Outputs registered (1 cycle); cfg_ready stays low from acceptance until the change is applied and settled.
module pll_cen_gen #(
   parameter  int NCH        = 2,
   parameter  int CNT_W      = 16,
   parameter  int LOCK_DELAY = 8,
   localparam int CH_W       = (NCH > 1) ? $clog2(NCH) : 1
) (
   input  logic             refclk,
   input  logic             rst,
   input  logic             cfg_valid,
   output logic             cfg_ready,
   input  logic [CH_W-1:0]  cfg_ch,
   input  logic [CNT_W-1:0] cfg_div,
   input  logic [CNT_W-1:0] cfg_high,
   input  logic [CNT_W-1:0] cfg_phase,
   output logic             cfg_err,
   input  logic             sync,
   output logic [NCH-1:0]   outclk,
   output logic [NCH-1:0]   ce,
   output logic             locked
);

   localparam int                SET_W       = $clog2(LOCK_DELAY + 1);
   localparam logic [SET_W-1:0]  SETTLE_INIT = SET_W'(LOCK_DELAY);
   localparam logic [SET_W-1:0]  SETTLE_ONE  = SET_W'(1);
   localparam logic [CNT_W-1:0]  ONE         = CNT_W'(1);
   localparam logic [CH_W:0]     NCH_L       = (CH_W + 1)'(NCH);

   typedef enum logic [1:0] {ST_SETTLE, ST_IDLE, ST_PEND} state_t;

   state_t           state_q, state_d;
   logic [SET_W-1:0] settle_q, settle_d;
   logic             exit_q, exit_d;
   logic [CH_W-1:0]  stg_ch_q, stg_ch_d;
   logic [CNT_W-1:0] stg_div_q, stg_div_d, stg_high_q, stg_high_d, stg_phase_q, stg_phase_d;
   logic [CNT_W-1:0] div_q [NCH];
   logic [CNT_W-1:0] div_d [NCH];
   logic [CNT_W-1:0] high_q [NCH];
   logic [CNT_W-1:0] high_d [NCH];
   logic [CNT_W-1:0] phase_q [NCH];
   logic [CNT_W-1:0] phase_d [NCH];
   logic [CNT_W-1:0] cnt_q [NCH];
   logic [CNT_W-1:0] cnt_d [NCH];
   logic [NCH-1:0]   outclk_q, outclk_d, ce_q, ce_d, wrap;
   logic             locked_q, locked_d, cfg_ready_q, cfg_ready_d, cfg_err_q, cfg_err_d;
   logic             cfg_ok, wrap_hit, apply, align;
   logic [CH_W-1:0]  app_ch;
   logic [CNT_W-1:0] app_div, app_high, app_phase;

   always_comb begin
      cfg_ok = ({1'b0, cfg_ch} < NCH_L) && (cfg_div != '0) &&
               (cfg_high <= cfg_div) && (cfg_phase < cfg_div);

      // Outside PEND, an apply can only come from a request arriving together with sync.
      app_ch    = (state_q == ST_PEND) ? stg_ch_q    : cfg_ch;
      app_div   = (state_q == ST_PEND) ? stg_div_q   : cfg_div;
      app_high  = (state_q == ST_PEND) ? stg_high_q  : cfg_high;
      app_phase = (state_q == ST_PEND) ? stg_phase_q : cfg_phase;

      wrap     = '0;
      wrap_hit = 1'b0;
      for (int i = 0; i < NCH; i++) begin
         wrap[i] = (cnt_q[i] == div_q[i] - ONE);
         if (CH_W'(i) == stg_ch_q) wrap_hit = wrap[i];
      end

      state_d     = state_q;
      settle_d    = settle_q;
      exit_d      = 1'b0;
      stg_ch_d    = stg_ch_q;
      stg_div_d   = stg_div_q;
      stg_high_d  = stg_high_q;
      stg_phase_d = stg_phase_q;
      cfg_err_d   = 1'b0;
      apply       = 1'b0;

      case (state_q)
         ST_SETTLE: begin
            if (settle_q <= SETTLE_ONE) state_d  = ST_IDLE;
            else                        settle_d = settle_q - SETTLE_ONE;
         end
         ST_IDLE: begin
            if (cfg_valid) begin
               if (cfg_ok) begin
                  stg_ch_d    = cfg_ch;
                  stg_div_d   = cfg_div;
                  stg_high_d  = cfg_high;
                  stg_phase_d = cfg_phase;
                  state_d     = ST_PEND;
               end else begin
                  cfg_err_d = 1'b1;
               end
            end
         end
         ST_PEND: begin
            if (wrap_hit) apply = 1'b1;
         end
         default: state_d = ST_SETTLE;
      endcase

      if (sync) begin
         if ((state_q == ST_PEND) || ((state_q == ST_IDLE) && cfg_valid && cfg_ok)) apply = 1'b1;
         settle_d = SETTLE_INIT;
         state_d  = ST_SETTLE;
      end
      if (apply) begin
         settle_d = SETTLE_INIT;
         state_d  = ST_SETTLE;
      end

      align = exit_q | sync | apply;

      for (int i = 0; i < NCH; i++) begin
         div_d[i]   = div_q[i];
         high_d[i]  = high_q[i];
         phase_d[i] = phase_q[i];
         if (apply && (CH_W'(i) == app_ch)) begin
            div_d[i]   = app_div;
            high_d[i]  = app_high;
            phase_d[i] = app_phase;
         end
         if (align)        cnt_d[i] = phase_d[i];
         else if (wrap[i]) cnt_d[i] = '0;
         else              cnt_d[i] = cnt_q[i] + ONE;
         // Outputs follow the counter value that will be held after this edge.
         ce_d[i]     = (cnt_d[i] == '0);
         outclk_d[i] = (cnt_d[i] < high_d[i]);
      end

      locked_d    = (state_d != ST_SETTLE);
      cfg_ready_d = (state_d == ST_IDLE);
   end

   always_ff @(posedge refclk) begin
      if (rst) begin
         state_q     <= ST_SETTLE;
         settle_q    <= SETTLE_INIT;
         exit_q      <= 1'b1;
         stg_ch_q    <= '0;
         stg_div_q   <= '0;
         stg_high_q  <= '0;
         stg_phase_q <= '0;
         for (int i = 0; i < NCH; i++) begin
            div_q[i]   <= CNT_W'(2);
            high_q[i]  <= ONE;
            phase_q[i] <= '0;
            cnt_q[i]   <= '0;
         end
         outclk_q    <= '0;
         ce_q        <= '0;
         locked_q    <= 1'b0;
         cfg_ready_q <= 1'b0;
         cfg_err_q   <= 1'b0;
      end else begin
         state_q     <= state_d;
         settle_q    <= settle_d;
         exit_q      <= exit_d;
         stg_ch_q    <= stg_ch_d;
         stg_div_q   <= stg_div_d;
         stg_high_q  <= stg_high_d;
         stg_phase_q <= stg_phase_d;
         for (int i = 0; i < NCH; i++) begin
            div_q[i]   <= div_d[i];
            high_q[i]  <= high_d[i];
            phase_q[i] <= phase_d[i];
            cnt_q[i]   <= cnt_d[i];
         end
         outclk_q    <= outclk_d;
         ce_q        <= ce_d;
         locked_q    <= locked_d;
         cfg_ready_q <= cfg_ready_d;
         cfg_err_q   <= cfg_err_d;
      end
   end

   assign outclk    = outclk_q;
   assign ce        = ce_q;
   assign locked    = locked_q;
   assign cfg_ready = cfg_ready_q;
   assign cfg_err   = cfg_err_q;

endmodule
